// File: rtl/ifetch_pair_if.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_pair_if
//  Description : Fetch-stage bundle: branch redirect, instruction memory
//                read port and decode-side pair handshake.
//                master = fetch stage, slave = surrounding pipeline/memory.
//  Revision    : 1.0  initial release
// ============================================================================
interface ifetch_pair_if #(
    parameter int PC_W = 9,
    parameter int IR_W = 16
);
    logic                  redirect_in;
    logic [PC_W-1:0]       redirect_pc_in;
    logic                  mem_rd_out;
    logic [PC_W-2:0]       mem_addr_out;
    logic [2*IR_W-1:0]     mem_rdata_in;
    logic                  dec_ready_in;
    logic                  pair_valid_out;
    logic [IR_W-1:0]       p0_IR_out;
    logic [IR_W-1:0]       p1_IR_out;
    logic [PC_W-1:0]       pc_out;
    logic                  ir0_invalid_out;
    logic                  fetch_next_out;

    modport master (
        input  redirect_in, redirect_pc_in, mem_rdata_in, dec_ready_in,
        output mem_rd_out, mem_addr_out, pair_valid_out, p0_IR_out,
               p1_IR_out, pc_out, ir0_invalid_out, fetch_next_out
    );

    modport slave (
        output redirect_in, redirect_pc_in, mem_rdata_in, dec_ready_in,
        input  mem_rd_out, mem_addr_out, pair_valid_out, p0_IR_out,
               p1_IR_out, pc_out, ir0_invalid_out, fetch_next_out
    );
endinterface
`default_nettype wire

// File: rtl/ifetch_pair.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_pair
//  Description : Dual-issue instruction fetch. Owns the fetch PC, reads one
//                {p1,p0} pair per cycle from synchronous instruction memory,
//                buffers pairs in a 2-entry queue and presents them with a
//                valid/ready handshake. A redirect flushes the queue and any
//                in-flight read and restarts fetch at the (possibly odd)
//                target; an odd target marks p0 of the first pair invalid.
//                Optional macro IFETCH_PERF_EN adds saturating stall/flush
//                performance counters.
//  Revision    : 1.0  initial release
// ============================================================================
module ifetch_pair #(
    parameter int PC_W   = 9,
    parameter int IR_W   = 16,
    parameter int QDEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    ifetch_pair_if.master    bus
`ifdef IFETCH_PERF_EN
    ,
    output logic [15:0]      perf_stall_out,
    output logic [15:0]      perf_flush_out
`endif
);

    localparam int c_cnt_w  = $clog2(QDEPTH + 1);
    localparam int c_idx_w  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int c_pair_w = 2 * IR_W;
    localparam logic [c_cnt_w:0] c_depth = (c_cnt_w + 1)'(QDEPTH);

    // fetch PC and skip flag for the next pair to be requested
    logic [PC_W-1:0]     r_fetch_pc;
    logic                r_skip;
    // tag of the read whose data arrives this cycle
    logic                r_inflight;
    logic [PC_W-1:0]     r_inflight_pc;
    logic                r_inflight_skip;
    // pair queue, entry 0 is the head
    logic [c_pair_w-1:0] r_q_ir   [QDEPTH];
    logic [PC_W-1:0]     r_q_pc   [QDEPTH];
    logic [QDEPTH-1:0]   r_q_skip;
    logic [c_cnt_w-1:0]  r_count;

    logic [c_pair_w-1:0] w_q_ir_nxt   [QDEPTH];
    logic [PC_W-1:0]     w_q_pc_nxt   [QDEPTH];
    logic [QDEPTH-1:0]   w_q_skip_nxt;
    logic [c_cnt_w-1:0]  w_count_nxt;
    logic [c_idx_w-1:0]  w_tail;

    logic                w_valid;
    logic                w_pop;
    logic                w_push;
    logic [c_cnt_w:0]    w_level;
    logic                w_issue;

    assign w_valid = (r_count != '0);
    // a redirect cancels the consume and the returning data
    assign w_pop   = w_valid & bus.dec_ready_in & ~bus.redirect_in;
    assign w_push  = r_inflight & ~bus.redirect_in;
    // slots committed for next cycle: the head being popped now frees its
    // slot, which is what sustains one pair per cycle with ready held high
    assign w_level = {1'b0, r_count} + (c_cnt_w + 1)'(r_inflight)
                   - (c_cnt_w + 1)'(w_pop);
    assign w_issue = ~rst & ~bus.redirect_in & (w_level < c_depth);

    assign bus.mem_rd_out      = w_issue;
    assign bus.mem_addr_out    = r_fetch_pc[PC_W-1:1];
    assign bus.pair_valid_out  = w_valid;
    assign bus.p0_IR_out       = w_valid ? r_q_ir[0][IR_W-1:0]        : '0;
    assign bus.p1_IR_out       = w_valid ? r_q_ir[0][c_pair_w-1:IR_W] : '0;
    assign bus.pc_out          = w_valid ? r_q_pc[0]                  : '0;
    assign bus.ir0_invalid_out = w_valid & r_q_skip[0];
    assign bus.fetch_next_out  = w_pop;

    // next queue contents: shift on pop, then append returning data at tail
    always_comb begin
        w_q_ir_nxt   = r_q_ir;
        w_q_pc_nxt   = r_q_pc;
        w_q_skip_nxt = r_q_skip;
        w_count_nxt  = r_count;
        w_tail       = c_idx_w'(r_count - c_cnt_w'(w_pop));
        if (bus.redirect_in) begin
            w_count_nxt = '0;
        end else begin
            if (w_pop) begin
                for (int i = 0; i < QDEPTH - 1; i++) begin
                    w_q_ir_nxt[i]   = r_q_ir[i+1];
                    w_q_pc_nxt[i]   = r_q_pc[i+1];
                    w_q_skip_nxt[i] = r_q_skip[i+1];
                end
            end
            if (w_push) begin
                w_q_ir_nxt[w_tail]   = bus.mem_rdata_in;
                w_q_pc_nxt[w_tail]   = r_inflight_pc;
                w_q_skip_nxt[w_tail] = r_inflight_skip;
            end
            w_count_nxt = r_count - c_cnt_w'(w_pop) + c_cnt_w'(w_push);
        end
    end

    // fetch PC, in-flight tag and queue registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc      <= '0;
            r_skip          <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_pc   <= '0;
            r_inflight_skip <= 1'b0;
            r_count         <= '0;
            r_q_skip        <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_ir[i] <= '0;
                r_q_pc[i] <= '0;
            end
        end else begin
            r_q_ir   <= w_q_ir_nxt;
            r_q_pc   <= w_q_pc_nxt;
            r_q_skip <= w_q_skip_nxt;
            r_count  <= w_count_nxt;
            if (bus.redirect_in) begin
                r_fetch_pc <= {bus.redirect_pc_in[PC_W-1:1], 1'b0};
                r_skip     <= bus.redirect_pc_in[0];
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_inflight_pc   <= r_fetch_pc;
                    r_inflight_skip <= r_skip;
                    r_fetch_pc      <= r_fetch_pc + PC_W'(2);
                    r_skip          <= 1'b0;
                end
            end
        end
    end

`ifdef IFETCH_PERF_EN
    logic [15:0] r_perf_stall;
    logic [15:0] r_perf_flush;
    logic [16:0] w_flush_sum;

    // pairs discarded by a redirect: queued entries plus the stale read
    assign w_flush_sum = {1'b0, r_perf_flush} + 17'(r_count) + 17'(r_inflight);

    // saturating stall and flush counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_valid && !bus.dec_ready_in && (r_perf_stall != 16'hFFFF))
                r_perf_stall <= r_perf_stall + 16'd1;
            if (bus.redirect_in)
                r_perf_flush <= w_flush_sum[16] ? 16'hFFFF : w_flush_sum[15:0];
        end
    end

    assign perf_stall_out = r_perf_stall;
    assign perf_flush_out = r_perf_flush;
`endif

endmodule
`default_nettype wire
